// File: rtl/rsa_encoder.sv
// rsa_encoder: computes data_out = data_in^e mod n by left-to-right square-and-multiply,
// with every modular product done by a bit-serial radix-2 Montgomery multiplier.
// Operands are kept in Montgomery form (x*R mod n) between multiplications.
module rsa_encoder #(
  parameter int               n_bit  = 7,
  parameter logic [n_bit-1:0] n      = 7'd79,
  parameter int               e_bit  = 3,
  parameter logic [e_bit-1:0] e      = 3'd5,
  parameter logic [n_bit-1:0] Rmodn  = 7'd49,
  parameter logic [n_bit-1:0] R2modn = 7'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [n_bit-1:0] data_in,
  output logic [n_bit-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam int cw = $clog2(n_bit + 1);
  localparam int iw = (e_bit > 1) ? $clog2(e_bit) : 1;
  localparam int tw = n_bit + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_SQR, S_MUL, S_POST, S_DONE
  } state_t;

  state_t           state, state_next;
  logic             start_d;
  logic             start_edge;
  logic [n_bit-1:0] m_reg;     // captured plaintext
  logic [n_bit-1:0] a_reg;     // running accumulator A, Montgomery form
  logic [n_bit-1:0] xbar;      // m in Montgomery form
  logic [tw-1:0]    t;         // Montgomery partial sum
  logic [cw-1:0]    cnt;       // cycle within the current multiplication
  logic [iw-1:0]    idx;       // exponent bit being scanned

  logic [n_bit-1:0] op_a, op_b;
  logic [n_bit:0]   a_ext;
  logic             a_bit;
  logic [tw-1:0]    sum_add, sum_red;
  logic [n_bit-1:0] mm_res;
  logic             mm_last;
  logic             in_mm;
  logic             scan_bit;
  logic             last_bit;

  assign start_edge = start & ~start_d;
  assign in_mm      = (state == S_PRE) || (state == S_SQR) ||
                      (state == S_MUL) || (state == S_POST);
  assign mm_last    = (cnt == cw'(n_bit));
  assign scan_bit   = e[idx];
  assign last_bit   = (idx == '0);

  // Multiplier operand selection for the current phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    op_a = a_reg;
    op_b = a_reg;
    case (state)
      S_PRE:   begin op_a = m_reg; op_b = R2modn; end
      S_MUL:   op_b = xbar;
      S_POST:  op_b = n_bit'(1);
      default: ;
    endcase
  end

  // One Montgomery iteration (conditional add, make even, halve) plus the final reduction.
  always_comb begin
    a_ext   = {1'b0, op_a};
    a_bit   = a_ext[cnt];
    sum_add = t + (a_bit ? tw'(op_b) : '0);
    sum_red = sum_add[0] ? sum_add + tw'(n) : sum_add;
    mm_res  = n_bit'((t >= tw'(n)) ? t - tw'(n) : t);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: left-to-right exponent scan, one multiplication per state visit.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_edge) state_next = S_LOAD;
      S_LOAD: state_next = S_PRE;
      S_PRE:  if (mm_last) state_next = S_SQR;
      S_SQR:  if (mm_last) begin
                if (scan_bit)      state_next = S_MUL;
                else if (last_bit) state_next = S_POST;
                else               state_next = S_SQR;
              end
      S_MUL:  if (mm_last) state_next = last_bit ? S_POST : S_SQR;
      S_POST: if (mm_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath, handshake and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      m_reg    <= '0;
      a_reg    <= '0;
      xbar     <= '0;
      t        <= '0;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= start_edge;
          if (start_edge) m_reg <= data_in;
        end
        S_LOAD: begin
          a_reg <= Rmodn;
          t     <= '0;
          cnt   <= '0;
          idx   <= iw'(e_bit - 1);
        end
        S_DONE: begin
          data_out <= a_reg;
          done     <= 1'b1;
        end
        default: begin
          if (in_mm) begin
            if (mm_last) begin
              t   <= '0;
              cnt <= '0;
              if (state == S_PRE) xbar  <= mm_res;
              else                a_reg <= mm_res;
              // Move to the next exponent bit once its square (and multiply, if any) is done.
              if ((state == S_MUL) || ((state == S_SQR) && !scan_bit))
                idx <= idx - 1'b1;
            end else begin
              t   <= sum_red >> 1;
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_encoder.sv
// tb_rsa_encoder: directed vectors, handshake corner cases and a full plaintext sweep
// against an independent repeated-multiplication model of m^e mod n.
module tb_rsa_encoder;

  localparam int N_BIT = 7;
  localparam int N     = 79;
  localparam int E     = 5;
  localparam int LAT   = 58;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_BIT-1:0] data_in;
  logic [N_BIT-1:0] data_out;
  logic             done;
  logic             busy;

  int checks = 0;
  int errors = 0;

  rsa_encoder #(
    .n_bit(7), .n(7'd79), .e_bit(3), .e(3'd5), .Rmodn(7'd49), .R2modn(7'd31)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_out(data_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int expect_c;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int modexp(input int m);
    int r = 1;
    for (int k = 0; k < E; k++) r = (r * m) % N;
    return r;
  endfunction

  // Raise start for one sampled edge (edge 0); leaves the bench just after edge 0.
  task automatic launch(input int m);
    @(negedge clk);
    start   = 1'b1;
    data_in = N_BIT'(m);
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = ~N_BIT'(m);
  endtask

  // Count cycles from edge 0 until done; optionally re-pulse start around cycle collide_at.
  task automatic wait_done(input int collide_at, output int lat, output int res);
    lat = -1;
    res = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == collide_at - 1) begin start = 1'b1; data_in = 7'd3; end
      if (c == collide_at) start = 1'b0;
      if (done) begin
        lat = c;
        res = int'(data_out);
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs[5];
    int lat, res, cnt_done;

    vecs[0] = '{m: 2,  expect_c: 32};
    vecs[1] = '{m: 10, expect_c: 65};
    vecs[2] = '{m: 0,  expect_c: 0};
    vecs[3] = '{m: 1,  expect_c: 1};
    vecs[4] = '{m: 78, expect_c: 78};

    rst = 1'b1; start = 1'b0; data_in = '0;
    #12;
    check("reset data_out", int'(data_out), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Known vectors: exact latency, value, single pulse, held output.
    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].m);
      check($sformatf("busy after start m=%0d", vecs[v].m), int'(busy), 1);
      wait_done(0, lat, res);
      check($sformatf("latency m=%0d", vecs[v].m), lat, LAT);
      check($sformatf("result m=%0d", vecs[v].m), res, vecs[v].expect_c);
      @(negedge clk);
      check($sformatf("done pulse width m=%0d", vecs[v].m), int'(done), 0);
      check($sformatf("data_out held m=%0d", vecs[v].m), int'(data_out), vecs[v].expect_c);
    end

    // Level start: held high across two operation lengths runs exactly once.
    @(negedge clk);
    start = 1'b1; data_in = 7'd2;
    cnt_done = 0;
    for (int c = 0; c < 2 * (LAT + 4); c++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("level start done count", cnt_done, 1);
    check("level start result", int'(data_out), 32);
    start = 1'b0;
    launch(10);
    wait_done(0, lat, res);
    check("restart latency", lat, LAT);
    check("restart result", res, 65);

    // Start edge while busy is ignored.
    launch(2);
    wait_done(20, lat, res);
    check("collision latency", lat, LAT);
    check("collision result", res, 32);
    cnt_done = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("collision not queued", cnt_done, 0);

    // Asynchronous reset mid-operation.
    launch(10);
    repeat (29) @(negedge clk);
    check("busy before mid-op reset", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset data_out", int'(data_out), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("no done after reset", cnt_done, 0);
    launch(2);
    wait_done(0, lat, res);
    check("post-reset latency", lat, LAT);
    check("post-reset result", res, 32);

    // Full sweep of legal plaintexts against the reference model.
    for (int m = 0; m < N; m++) begin
      launch(m);
      wait_done(0, lat, res);
      check($sformatf("sweep m=%0d", m), res, modexp(m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
